// File: rtl/vsq_scale_sequencer.sv
// Per-vector scale sequencer: fetches one factor pair per vector, then streams
// VEC_LEN partial sums through a scale/shift/saturate stage with 1-cycle latency.
module vsq_scale_sequencer #(
    parameter int VEC_LEN = 16,
    parameter int PSUM_W  = 24,
    parameter int FACT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_vsq,
    input  logic [7:0]        num_vectors,
    input  logic              fact_valid,
    output logic              fact_ready,
    input  logic [FACT_W-1:0] a_factor,
    input  logic [FACT_W-1:0] b_factor,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] in_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_psum,
    output logic              busy,
    output logic              done
);

    localparam int EW = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;
    localparam int PW = PSUM_W + 17;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;

    state_t              state;
    logic                mode_vsq;
    logic [7:0]          nvec;
    logic [EW-1:0]       elem_cnt;
    logic [7:0]          vec_cnt;
    logic [15:0]         scale;
    logic [2*FACT_W-1:0] fact_prod;
    logic                transfer;
    logic                last_elem;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] shifted;
    logic [PSUM_W-1:0]   scaled;

    assign fact_ready = (state == FETCH);
    assign busy       = (state != IDLE);
    assign in_ready   = (state == STREAM) && (!out_valid || out_ready);
    assign done       = (state == FINISH) && (!out_valid || out_ready);
    assign transfer   = in_valid && in_ready;
    assign last_elem  = (elem_cnt == EW'(VEC_LEN - 1));
    assign fact_prod  = a_factor * b_factor;

    // Scale is Q8.8: multiply, floor-shift by 8, then clamp to the psum range.
    always_comb begin
        product = $signed(in_psum) * $signed({1'b0, scale});
        shifted = product >>> 8;
        scaled  = shifted[PSUM_W-1:0];
        if (shifted > SAT_MAX)
            scaled = SAT_MAX[PSUM_W-1:0];
        else if (shifted < SAT_MIN)
            scaled = SAT_MIN[PSUM_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_vsq  <= 1'b0;
            nvec      <= '0;
            elem_cnt  <= '0;
            vec_cnt   <= '0;
            scale     <= '0;
            out_valid <= 1'b0;
            out_psum  <= '0;
        end else begin
            // Output register drains in any state so a pending result survives FETCH/FINISH.
            if (transfer) begin
                out_valid <= 1'b1;
                out_psum  <= mode_vsq ? scaled : in_psum;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_vsq <= is_vsq;
                        nvec     <= num_vectors;
                        elem_cnt <= '0;
                        vec_cnt  <= '0;
                        state    <= (num_vectors == 8'd0) ? FINISH : FETCH;
                    end
                end
                FETCH: begin
                    if (fact_valid) begin
                        scale <= mode_vsq ? 16'(fact_prod) : 16'd256;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        if (last_elem) begin
                            elem_cnt <= '0;
                            vec_cnt  <= vec_cnt + 8'd1;
                            state    <= (({1'b0, vec_cnt} + 9'd1) < {1'b0, nvec}) ? FETCH : FINISH;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    if (!out_valid || out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
